neuron_acc_ctrl: RTL and testbench



---
 rtl/neuron_acc_ctrl.sv | 104 ++++++++++
 tb/tb_neuron_acc_ctrl.sv | 230 +++++++++++++++++++++++
 2 files changed

// File: rtl/neuron_acc_ctrl.sv
// Neuron accumulate sequencer: sums N_TERMS signed terms plus a bias
// through a symmetric saturating adder, then offers the result on valid/ready.
module neuron_acc_ctrl #(
    parameter int W       = 4,
    parameter int N_TERMS = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic [W-1:0] bias,
    input  logic         term_valid,
    output logic         term_ready,
    input  logic [W-1:0] term_data,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] out_data,
    output logic         busy
);

    localparam int CW = $clog2(N_TERMS + 1);
    localparam logic [CW-1:0] LAST = CW'(N_TERMS - 1);
    localparam logic [W-1:0] MAXV  = {1'b0, {(W-1){1'b1}}};
    localparam logic [W-1:0] MINV  = {1'b1, {(W-1){1'b0}}};
    localparam logic [W-1:0] NMAXV = MINV + 1'b1;

    typedef enum logic [1:0] {IDLE, ACCUM, BIAS, DONE} state_t;

    state_t        state;
    logic [W-1:0]  acc;
    logic [W-1:0]  bias_q;
    logic [CW-1:0] cnt;

    // The most negative code is folded onto -MAXV so the range stays symmetric.
    function automatic logic [W-1:0] cond(input logic [W-1:0] x);
        return (x == MINV) ? NMAXV : x;
    endfunction

    function automatic logic [W-1:0] sat_add(input logic [W-1:0] a,
                                             input logic [W-1:0] b);
        logic signed [W:0] s;
        logic signed [W:0] hi;
        logic signed [W:0] lo;
        s  = $signed({a[W-1], a}) + $signed({b[W-1], b});
        hi = $signed({1'b0, MAXV});
        lo = $signed({1'b1, NMAXV});
        if (s > hi)
            return MAXV;
        else if (s < lo)
            return NMAXV;
        else
            return s[W-1:0];
    endfunction

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            acc        <= '0;
            bias_q     <= '0;
            cnt        <= '0;
            term_ready <= 1'b0;
            out_valid  <= 1'b0;
            out_data   <= '0;
            busy       <= 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (start) begin
                        bias_q     <= cond(bias);
                        acc        <= '0;
                        cnt        <= '0;
                        term_ready <= 1'b1;
                        busy       <= 1'b1;
                        state      <= ACCUM;
                    end
                end
                ACCUM: begin
                    if (term_valid && term_ready) begin
                        acc <= sat_add(acc, cond(term_data));
                        cnt <= cnt + 1'b1;
                        if (cnt == LAST) begin
                            term_ready <= 1'b0;
                            state      <= BIAS;
                        end
                    end
                end
                BIAS: begin
                    acc       <= sat_add(acc, bias_q);
                    out_data  <= sat_add(acc, bias_q);
                    out_valid <= 1'b1;
                    state     <= DONE;
                end
                DONE: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        out_data  <= '0;
                        busy      <= 1'b0;
                        state     <= IDLE;
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_neuron_acc_ctrl.sv
// Directed bench for neuron_acc_ctrl (W=4, N_TERMS=4).
// Expected results are hand-computed saturating sums.
module tb_neuron_acc_ctrl;

    localparam int W = 4;
    localparam int N = 4;

    logic         clk = 1'b0;
    logic         rst;
    logic         start;
    logic [W-1:0] bias;
    logic         term_valid;
    logic         term_ready;
    logic [W-1:0] term_data;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] out_data;
    logic         busy;

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    neuron_acc_ctrl #(.W(W), .N_TERMS(N)) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .bias       (bias),
        .term_valid (term_valid),
        .term_ready (term_ready),
        .term_data  (term_data),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_data   (out_data),
        .busy       (busy)
    );

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic run(input logic [3:0] b, input logic [15:0] t,
                       output logic [3:0] res, output int lat,
                       output logic busy_after);
        int k;
        start = 1'b1;
        bias  = b;
        tick();
        start = 1'b0;
        bias  = '0;
        k = 0;
        for (int i = 0; i < N; i++) begin
            term_valid = 1'b1;
            term_data  = t[4*i +: 4];
            tick();
            k++;
        end
        term_valid = 1'b0;
        while (!out_valid && k < 30) begin
            tick();
            k++;
        end
        lat = k + 1;
        res = out_data;
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        busy_after = busy;
    endtask

    logic [3:0] r;
    int         l;
    logic       b;
    int         k;

    initial begin
        rst        = 1'b1;
        start      = 1'b0;
        bias       = '0;
        term_valid = 1'b0;
        term_data  = '0;
        out_ready  = 1'b0;
        tick();
        tick();
        check("rst_term_ready", term_ready, 0);
        check("rst_out_valid", out_valid, 0);
        check("rst_out_data", out_data, 0);
        check("rst_busy", busy, 0);
        rst = 1'b0;
        tick();

        // 1: basic, 1+2+3-1 = 5
        run(4'd0, {4'hF, 4'd3, 4'd2, 4'd1}, r, l, b);
        check("t1_data", r, 5);
        check("t1_lat", l, 6);
        check("t1_busy_after", b, 0);

        // 2: intermediate saturation
        run(4'd0, {4'hD, 4'hD, 4'd7, 4'd7}, r, l, b);
        check("t2a_data", r, 1);
        run(4'hD, {4'd2, 4'h9, 4'h9, 4'h9}, r, l, b);
        check("t2b_data", r, 4'h9);

        // 3: input conditioning of -8
        run(4'h8, {4'd0, 4'd0, 4'd0, 4'h8}, r, l, b);
        check("t3a_data", r, 4'h9);
        run(4'h0, {4'd0, 4'd0, 4'd7, 4'h8}, r, l, b);
        check("t3b_data", r, 0);

        // 4: stalls, ignored starts, output backpressure; 3-2+4+1+1 = 7
        start = 1'b1;
        bias  = 4'd1;
        tick();
        start = 1'b0;
        bias  = '0;
        for (int i = 0; i < N; i++) begin
            logic [15:0] tv;
            tv = {4'd1, 4'd4, 4'hE, 4'd3};
            term_valid = 1'b0;
            start = (i == 1);
            tick();
            start = 1'b0;
            check("t4_cnt_gap", dut.cnt, i);
            term_valid = 1'b1;
            term_data  = tv[4*i +: 4];
            tick();
            term_valid = 1'b0;
            check("t4_cnt_acc", dut.cnt, i + 1);
        end
        k = 0;
        while (!out_valid && k < 20) begin
            tick();
            k++;
        end
        check("t4_valid", out_valid, 1);
        check("t4_data", out_data, 7);
        for (int j = 0; j < 5; j++) begin
            start = (j == 2);
            tick();
            start = 1'b0;
            check("t4_hold_valid", out_valid, 1);
            check("t4_hold_data", out_data, 7);
        end
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        check("t4_busy_after", busy, 0);
        tick();
        tick();
        tick();
        check("t4_no_second_valid", out_valid, 0);
        check("t4_no_second_busy", busy, 0);

        // 5: reset mid-operation
        start = 1'b1;
        tick();
        start = 1'b0;
        term_valid = 1'b1;
        term_data  = 4'd7;
        tick();
        tick();
        term_valid = 1'b0;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("t5_term_ready", term_ready, 0);
        check("t5_out_valid", out_valid, 0);
        check("t5_out_data", out_data, 0);
        check("t5_busy", busy, 0);
        check("t5_acc", dut.acc, 0);
        run(4'd2, {4'd1, 4'd1, 4'd1, 4'd1}, r, l, b);
        check("t5_data", r, 6);

        // 6: back-to-back with out_ready tied high
        out_ready = 1'b1;
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int i = 0; i < N; i++) begin
            term_valid = 1'b1;
            term_data  = 4'd2;
            tick();
        end
        term_valid = 1'b0;
        k = 0;
        while (!out_valid && k < 20) begin
            tick();
            k++;
        end
        check("t6_first_data", out_data, 7);
        start = 1'b1;
        bias  = 4'hF;
        tick();
        check("t6_start_on_hs_ignored", busy, 0);
        tick();
        start = 1'b0;
        bias  = '0;
        check("t6_start_next_accepted", busy, 1);
        for (int i = 0; i < N; i++) begin
            term_valid = 1'b1;
            term_data  = 4'hF;
            tick();
        end
        term_valid = 1'b0;
        k = 0;
        while (!out_valid && k < 20) begin
            tick();
            k++;
        end
        check("t6_second_data", out_data, 4'hB);
        tick();
        out_ready = 1'b0;
        check("t6_busy_after", busy, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
